// File: rtl/rgb2raw_bayer_mosaic_if.sv
// Pixel stream bundle for the RGB -> Bayer re-mosaic block: RGB input with strobes,
// single-channel raw output with strobes and framing-error pulses.
interface rgb2raw_bayer_mosaic_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] g_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  data_valid;
  logic                  data_sop;
  logic                  data_eop;

  logic [DATA_WIDTH-1:0] raw_data;
  logic                  raw_valid;
  logic                  raw_sop;
  logic                  raw_eop;
  logic                  raw_sof;
  logic                  len_err;
  logic                  sop_err;

  modport master (
    output r_data, g_data, b_data, data_valid, data_sop, data_eop,
    input  raw_data, raw_valid, raw_sop, raw_eop, raw_sof, len_err, sop_err
  );

  modport slave (
    input  r_data, g_data, b_data, data_valid, data_sop, data_eop,
    output raw_data, raw_valid, raw_sop, raw_eop, raw_sof, len_err, sop_err
  );
endinterface

// File: rtl/rgb2raw_bayer_mosaic.sv
// Re-mosaics a full-RGB pixel stream into an RGGB Bayer raw stream (2-clock latency),
// tracking line/column position and pulsing framing errors alongside the offending sample.
module rgb2raw_bayer_mosaic #(
  parameter int DATA_WIDTH = 8,
  parameter int PIXELS     = 1280,
  parameter int LINES      = 720
) (
  input  logic                         clk,
  input  logic                         reset,
  rgb2raw_bayer_mosaic_if.slave        bus
);
  localparam int COL_W  = $clog2(PIXELS + 1);
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PIXELS - 1);
  localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(PIXELS);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [COL_W-1:0]    r_col_cnt, w_col_cnt_nxt, w_pix_col;
  logic [LINE_W-1:0]   r_line_cnt, w_line_cnt_nxt;
  logic                r_col_par, w_col_par_nxt, w_pix_cpar;
  logic                w_accept, w_sop_err, w_len_err, w_sof;

  logic                  r_vld_p0, r_sop_p0, r_eop_p0, r_sof_p0;
  logic                  r_lerr_p0, r_serr_p0, r_lpar_p0, r_cpar_p0;
  logic [DATA_WIDTH-1:0] r_r_p0, r_g_p0, r_b_p0;

  logic                  r_vld_p1, r_sop_p1, r_eop_p1, r_sof_p1;
  logic                  r_lerr_p1, r_serr_p1;
  logic [DATA_WIDTH-1:0] r_raw_p1;

  function automatic logic [DATA_WIDTH-1:0] bayer_sel(
    input logic                  lpar,
    input logic                  cpar,
    input logic [DATA_WIDTH-1:0] r,
    input logic [DATA_WIDTH-1:0] g,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] sel;
    case ({lpar, cpar})
      2'b00:   sel = r;
      2'b11:   sel = b;
      default: sel = g;
    endcase
    return sel;
  endfunction

  // Column parity is kept separately so it keeps alternating past the saturated column count.
  always_comb begin
    w_state_nxt    = r_state;
    w_col_cnt_nxt  = r_col_cnt;
    w_line_cnt_nxt = r_line_cnt;
    w_col_par_nxt  = r_col_par;
    w_pix_col      = r_col_cnt;
    w_pix_cpar     = r_col_par;
    w_accept       = 1'b0;
    w_sop_err      = 1'b0;
    w_len_err      = 1'b0;
    w_sof          = 1'b0;
    if (bus.data_valid) begin
      if (bus.data_sop) begin
        w_accept   = 1'b1;
        w_sop_err  = (r_state == S_LINE);
        w_pix_col  = '0;
        w_pix_cpar = 1'b0;
        w_sof      = (r_line_cnt == '0);
      end else if (r_state == S_LINE) begin
        w_accept = 1'b1;
      end else begin
        w_sop_err = 1'b1;
      end
    end
    if (w_accept) begin
      w_state_nxt   = S_LINE;
      w_col_cnt_nxt = (w_pix_col == COL_SAT) ? COL_SAT : w_pix_col + COL_W'(1);
      w_col_par_nxt = ~w_pix_cpar;
      if (bus.data_eop) begin
        w_len_err = (w_pix_col != COL_LAST);
        if (r_line_cnt == LINE_LAST) begin
          w_state_nxt    = S_IDLE;
          w_line_cnt_nxt = '0;
        end else begin
          w_state_nxt    = S_GAP;
          w_line_cnt_nxt = r_line_cnt + LINE_W'(1);
        end
      end else begin
        w_len_err = (w_pix_col == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_cnt  <= '0;
      r_line_cnt <= '0;
      r_col_par  <= 1'b0;
    end else begin
      r_col_cnt  <= w_col_cnt_nxt;
      r_line_cnt <= w_line_cnt_nxt;
      r_col_par  <= w_col_par_nxt;
    end
  end

  // Stage 0: capture components, position parity and strobes of the accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p0  <= 1'b0;
      r_sop_p0  <= 1'b0;
      r_eop_p0  <= 1'b0;
      r_sof_p0  <= 1'b0;
      r_lerr_p0 <= 1'b0;
      r_serr_p0 <= 1'b0;
      r_lpar_p0 <= 1'b0;
      r_cpar_p0 <= 1'b0;
      r_r_p0    <= '0;
      r_g_p0    <= '0;
      r_b_p0    <= '0;
    end else begin
      r_vld_p0  <= w_accept;
      r_sop_p0  <= w_accept & bus.data_sop;
      r_eop_p0  <= w_accept & bus.data_eop;
      r_sof_p0  <= w_accept & w_sof;
      r_lerr_p0 <= w_len_err;
      r_serr_p0 <= w_sop_err;
      if (w_accept) begin
        r_lpar_p0 <= r_line_cnt[0];
        r_cpar_p0 <= w_pix_cpar;
        r_r_p0    <= bus.r_data;
        r_g_p0    <= bus.g_data;
        r_b_p0    <= bus.b_data;
      end
    end
  end

  // Stage 1: Bayer select; raw_data holds its last value across invalid cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_sop_p1  <= 1'b0;
      r_eop_p1  <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_lerr_p1 <= 1'b0;
      r_serr_p1 <= 1'b0;
      r_raw_p1  <= '0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_sop_p1  <= r_sop_p0;
      r_eop_p1  <= r_eop_p0;
      r_sof_p1  <= r_sof_p0;
      r_lerr_p1 <= r_lerr_p0;
      r_serr_p1 <= r_serr_p0;
      if (r_vld_p0) r_raw_p1 <= bayer_sel(r_lpar_p0, r_cpar_p0, r_r_p0, r_g_p0, r_b_p0);
    end
  end

  assign bus.raw_data  = r_raw_p1;
  assign bus.raw_valid = r_vld_p1;
  assign bus.raw_sop   = r_sop_p1;
  assign bus.raw_eop   = r_eop_p1;
  assign bus.raw_sof   = r_sof_p1;
  assign bus.len_err   = r_lerr_p1;
  assign bus.sop_err   = r_serr_p1;
endmodule

// File: tb/tb_rgb2raw_bayer_mosaic.sv
// Bench for rgb2raw_bayer_mosaic on a 4x2 frame: directed vector table, async reset
// sequences and randomized framing checked against a position-tracking RGGB model.
module tb_rgb2raw_bayer_mosaic;
  localparam int DW  = 8;
  localparam int PIX = 4;
  localparam int LIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rgb2raw_bayer_mosaic_if #(.DATA_WIDTH(DW)) bus();

  rgb2raw_bayer_mosaic #(.DATA_WIDTH(DW), .PIXELS(PIX), .LINES(LIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          sof;
    logic          lerr;
    logic          serr;
  } out_t;

  typedef struct {
    logic v;
    logic s;
    logic e;
    out_t x;
  } vec_t;

  vec_t  tbl[$];
  int    n_vec = 0;
  int    n_bad = 0;
  out_t  exp_d1;
  bit    chk_d1;
  string nm_d1;

  bit            m_inline;
  int            m_line;
  int            m_col;
  logic [DW-1:0] m_last;

  // Reference: the pixel's position in the frame picks R/G/B from the RGGB tile.
  function automatic out_t model_step(input logic v, input logic s, input logic e,
                                      input logic [DW-1:0] r, input logic [DW-1:0] g,
                                      input logic [DW-1:0] b);
    out_t x;
    int   row_odd, col_odd;
    x = '0;
    if (v) begin
      if (!m_inline && !s) begin
        x.serr = 1'b1;
      end else begin
        if (s) begin
          x.serr   = m_inline;
          m_inline = 1'b1;
          m_col    = 0;
        end
        row_odd = m_line % 2;
        col_odd = m_col % 2;
        x.vld = 1'b1;
        x.sop = s;
        x.eop = e;
        x.sof = s && (m_line == 0);
        if (row_odd == 0 && col_odd == 0)      x.data = r;
        else if (row_odd == 1 && col_odd == 1) x.data = b;
        else                                   x.data = g;
        if (e) begin
          x.lerr   = (m_col != PIX - 1);
          m_inline = 1'b0;
          m_line   = (m_line == LIN - 1) ? 0 : m_line + 1;
        end else begin
          x.lerr = (m_col == PIX - 1);
        end
        m_col++;
      end
    end
    return x;
  endfunction

  task automatic check(input string nm, input out_t x);
    out_t a;
    a = {bus.raw_valid, bus.raw_data, bus.raw_sop, bus.raw_eop, bus.raw_sof,
         bus.len_err, bus.sop_err};
    n_vec++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got v=%b d=%h sop=%b eop=%b sof=%b len_err=%b sop_err=%b, expected v=%b d=%h sop=%b eop=%b sof=%b len_err=%b sop_err=%b",
               nm, a.vld, a.data, a.sop, a.eop, a.sof, a.lerr, a.serr,
               x.vld, x.data, x.sop, x.eop, x.sof, x.lerr, x.serr);
    end
  endtask

  // One clock: drive a pixel, then compare the outputs due from the previous pixel.
  task automatic step(input logic v, input logic s, input logic e,
                      input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b,
                      input bit use_x, input out_t xt, input string nm);
    out_t mx, x;
    bus.data_valid = v;
    bus.data_sop   = s;
    bus.data_eop   = e;
    bus.r_data     = r;
    bus.g_data     = g;
    bus.b_data     = b;
    mx = model_step(v, s, e, r, g, b);
    x  = use_x ? xt : mx;
    if (x.vld) m_last = x.data;
    else       x.data = m_last;
    @(posedge clk);
    #1;
    if (chk_d1) check(nm_d1, exp_d1);
    exp_d1 = x;
    chk_d1 = 1'b1;
    nm_d1  = nm;
  endtask

  task automatic model_reset();
    m_inline = 1'b0;
    m_line   = 0;
    m_col    = 0;
    m_last   = '0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_sop   = 1'b0;
    bus.data_eop   = 1'b0;
    bus.r_data     = '0;
    bus.g_data     = '0;
    bus.b_data     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", '0);
    reset  = 1'b0;
    exp_d1 = '0;
    chk_d1 = 1'b1;
    nm_d1  = "post_reset";
  endtask

  function automatic void add(input logic v, input logic s, input logic e,
                              input logic xv, input logic [DW-1:0] d, input logic xs,
                              input logic xe, input logic xf, input logic xl, input logic xr);
    vec_t t;
    t.v = v;
    t.s = s;
    t.e = e;
    t.x = {xv, d, xs, xe, xf, xl, xr};
    tbl.push_back(t);
  endfunction

  initial begin
    // Flat-colour 4x2 frame: R=10, G=20, B=30.
    add(1,1,0, 1,8'h10,1,0,1,0,0); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,0,0, 1,8'h10,0,0,0,0,0); add(1,0,1, 1,8'h20,0,1,0,0,0);
    add(0,0,0, 0,8'h00,0,0,0,0,0);
    add(1,1,0, 1,8'h20,1,0,0,0,0); add(1,0,0, 1,8'h30,0,0,0,0,0);
    add(1,0,0, 1,8'h20,0,0,0,0,0); add(1,0,1, 1,8'h30,0,1,0,0,0);
    // Short line then a normal odd line (with a mid-line gap).
    add(1,1,0, 1,8'h10,1,0,1,0,0); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,0,1, 1,8'h10,0,1,0,1,0);
    add(1,1,0, 1,8'h20,1,0,0,0,0); add(0,0,0, 0,8'h00,0,0,0,0,0);
    add(1,0,0, 1,8'h30,0,0,0,0,0); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,0,1, 1,8'h30,0,1,0,0,0);
    // sop inside a line restarts at col 0; stray pixel in the gap is dropped.
    add(1,1,0, 1,8'h10,1,0,1,0,0); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,1,0, 1,8'h10,1,0,1,0,1); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,0,0, 1,8'h10,0,0,0,0,0); add(1,0,1, 1,8'h20,0,1,0,0,0);
    add(1,0,0, 0,8'h00,0,0,0,0,1);
    // Single-pixel line with sop&eop closes the frame; stray pixel in idle is dropped.
    add(1,1,1, 1,8'h20,1,1,0,1,0); add(1,0,1, 0,8'h00,0,0,0,0,1);
    // Overlong line: error at the missing eop, parity continues, error again at late eop.
    add(1,1,0, 1,8'h10,1,0,1,0,0); add(1,0,0, 1,8'h20,0,0,0,0,0);
    add(1,0,0, 1,8'h10,0,0,0,0,0); add(1,0,0, 1,8'h20,0,0,0,1,0);
    add(1,0,0, 1,8'h10,0,0,0,0,0); add(1,0,1, 1,8'h20,0,1,0,1,0);
    add(1,1,0, 1,8'h20,1,0,0,0,0); add(1,0,0, 1,8'h30,0,0,0,0,0);
    add(1,0,0, 1,8'h20,0,0,0,0,0); add(1,0,1, 1,8'h30,0,1,0,0,0);
    add(0,1,1, 0,8'h00,0,0,0,0,0);

    // Quiet after reset.
    do_reset();
    for (int i = 0; i < 100; i++) step(0, 0, 0, '0, '0, '0, 1'b0, '0, "idle");

    // Directed table.
    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].v, tbl[i].s, tbl[i].e, 8'h10, 8'h20, 8'h30, 1'b1, tbl[i].x,
           $sformatf("tbl%0d", i));
    step(0, 0, 0, '0, '0, '0, 1'b0, '0, "tbl_flush");

    // Asynchronous reset in the middle of line 1 with samples in flight.
    do_reset();
    for (int c = 0; c < PIX; c++)
      step(1, c == 0, c == PIX - 1, 8'h10, 8'h20, 8'h30, 1'b0, '0, "pre_line0");
    step(1, 1, 0, 8'h10, 8'h20, 8'h30, 1'b0, '0, "pre_line1_c0");
    step(1, 0, 0, 8'h10, 8'h20, 8'h30, 1'b0, '0, "pre_line1_c1");
    step(1, 0, 0, 8'h10, 8'h20, 8'h30, 1'b0, '0, "pre_line1_c2");
    reset = 1'b1;
    #1;
    check("async_reset_outputs", '0);
    model_reset();
    bus.data_valid = 1'b0;
    @(posedge clk);
    #1;
    check("async_reset_held", '0);
    reset  = 1'b0;
    exp_d1 = '0;
    chk_d1 = 1'b1;
    nm_d1  = "post_async_reset";
    step(1, 1, 0, 8'h10, 8'h20, 8'h30, 1'b1, {1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, "restart_R");
    step(1, 0, 0, 8'h10, 8'h20, 8'h30, 1'b1, {1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, "restart_G");
    step(1, 0, 0, 8'h10, 8'h20, 8'h30, 1'b0, '0, "restart_c2");
    step(1, 0, 1, 8'h10, 8'h20, 8'h30, 1'b0, '0, "restart_c3");
    step(0, 0, 0, '0, '0, '0, 1'b0, '0, "restart_flush");

    // Randomized frames: gaps with junk strobes, odd line lengths, stray pixels, early sops.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      for (int l = 0; l < LIN; l++) begin
        int len, k;
        k = $urandom_range(0, 9);
        len = PIX;
        if (k == 0)      len = PIX - 1;
        else if (k == 1) len = PIX + 2;
        for (int c = 0; c < len; c++) begin
          logic s;
          while ($urandom_range(0, 3) == 0)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom,
                 1'b0, '0, "rand_gap");
          s = (c == 0) || ($urandom_range(0, 30) == 0);
          step(1, s, c == len - 1, $urandom, $urandom, $urandom, 1'b0, '0, "rand_pix");
        end
        if ($urandom_range(0, 9) == 0)
          step(1, 0, $urandom_range(0, 1), $urandom, $urandom, $urandom, 1'b0, '0, "rand_stray");
      end
    end
    step(0, 0, 0, '0, '0, '0, 1'b0, '0, "rand_flush");
    step(0, 0, 0, '0, '0, '0, 1'b0, '0, "rand_flush2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
